fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program counter / fetch stage of the 9-bit CSE141L core. Holds ProgCtr, which drives the
//  combinational instruction ROM; the ROM word feeds the control decoder. Consumes the decoder's
//  JumpEqual/JumpNotEqual/Ack plus the ALU Equal flag to pick the next PC.
//  Sequences a program run: idle -> run -> halt, with a Start handshake and a Done flag.
// PARAMETERS
//  PC_W   10  program counter / instruction ROM address width (bits)
//  CNT_W  16  width of the optional performance counters
// PORTS
//  Clk         in   1      core clock; all state updates on rising edge
//  Reset       in   1      synchronous, active-low reset (sampled on Clk rising edge)
//  Start       in   1      begin program run at StartAddr (level, sampled in IDLE/HALT)
//  StartAddr   in   PC_W   first instruction address of the run
//  JumpEqual   in   1      decoder: current instruction is je
//  JumpNotEqual in  1      decoder: current instruction is jne
//  Equal       in   1      ALU equality flag for the current branch
//  Target      in   PC_W   absolute jump target (from top-level target LUT)
//  Ack         in   1      decoder: current instruction is the halt word (9'h1FF)
//  ProgCtr     out  PC_W   address to instruction ROM
//  Running     out  1      1 while in RUN; decoder outputs are meaningful only then
//  Done        out  1      1 while in HALT
//  CycleCt     out  CNT_W  RUN cycles this run (optional feature)
//  JumpCt      out  CNT_W  taken jumps this run (optional feature)
// BEHAVIOUR
//  - Reset=0 at an edge: state IDLE, ProgCtr=0, Running=0, Done=0, CycleCt=0, JumpCt=0.
//    Reset dominates every other input, including mid-run; no partial update survives.
//  - States: IDLE, RUN, HALT. Running=(state==RUN), Done=(state==HALT), both registered-state decode.
//  - IDLE: Start=1 -> RUN, ProgCtr<=StartAddr, counters<=0. Start=0 -> stay, ProgCtr holds.
//  - RUN, per edge, priority order:
//     1. Ack=1 -> HALT; ProgCtr holds (keeps pointing at halt word); no jump taken even if
//        JumpEqual/JumpNotEqual also high.
//     2. taken = (JumpEqual & Equal) | (JumpNotEqual & ~Equal); taken -> ProgCtr<=Target.
//        JumpEqual & JumpNotEqual both high -> unconditional jump to Target.
//     3. else ProgCtr<=ProgCtr+1, modulo 2^PC_W (max address wraps to 0, no flag).
//     Start is ignored in RUN.
//  - HALT: Start=1 -> RUN, ProgCtr<=StartAddr, counters<=0 (same as IDLE). Else hold all.
//  - Latency: ProgCtr changes exactly one edge after the decision inputs; ROM/decoder path is
//    combinational, so one instruction per cycle, no bubbles, jump penalty 0 cycles.
//  - Target, Equal and jump inputs are don't-care outside RUN.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   - CycleCt +1 on every edge spent in RUN (including the Ack edge); JumpCt +1 per taken jump.
//   - Both saturate at 2^CNT_W-1; cleared on reset and on each Start launch; hold in HALT.
//  FETCH_PERF_CNT_EN undefined: CycleCt and JumpCt tied to 0; no counter flops; ports remain.
// TESTING
//  1. Reset=0 two edges, then Reset=1, Start=0 -> ProgCtr=0, Running=0, Done=0 held 5 cycles.
//  2. StartAddr=10'd4, Start pulse, no jumps, Ack at PC=7 -> ProgCtr 4,5,6,7,7...; Done=1 from
//     the edge after PC=7; with FETCH_PERF_CNT_EN CycleCt=4, JumpCt=0.
//  3. At PC=5: JumpEqual=1,Equal=1,Target=20 -> next PC=20; JumpEqual=1,Equal=0 -> PC=6;
//     JumpNotEqual=1,Equal=0,Target=3 -> PC=3; JumpCt counts only the taken ones.
//  4. StartAddr=10'h3FE, run with no jumps -> ProgCtr 3FE,3FF,000,001.
//  5. Ack=1 and JumpEqual=1,Equal=1 same cycle at PC=9 -> HALT, ProgCtr stays 9; then Start with
//     StartAddr=0 -> RUN at PC=0, counters cleared.
//  6. Reset=0 asserted mid-run at PC=12 -> next edge IDLE, ProgCtr=0, counters 0, Start
//     ignored during that edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Program counter / fetch sequencer for the 9-bit core: IDLE -> RUN -> HALT with Start/Done.
// Optional run statistics (CycleCt, JumpCt) are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             JumpEqual,
  input  logic             JumpNotEqual,
  input  logic             Equal,
  input  logic [PC_W-1:0]  Target,
  input  logic             Ack,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCt,
  output logic [CNT_W-1:0] JumpCt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken;
  logic            launch;

  // Both jump flags high makes the branch unconditional.
  assign taken  = (JumpEqual & Equal) | (JumpNotEqual & ~Equal);
  assign launch = (state_q != RUN) && Start;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (Ack)   state_d = HALT;
      HALT:    if (Start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Running = (state_q == RUN);
    Done    = (state_q == HALT);
  end

  // Ack wins over any jump so the PC keeps pointing at the halt word.
  always_comb begin
    pc_d = pc_q;
    if (launch) begin
      pc_d = StartAddr;
    end else if (state_q == RUN) begin
      if (Ack)        pc_d = pc_q;
      else if (taken) pc_d = Target;
      else            pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign ProgCtr = pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] jmp_q, jmp_d;

  always_comb begin
    cyc_d = cyc_q;
    jmp_d = jmp_q;
    if (launch) begin
      cyc_d = '0;
      jmp_d = '0;
    end else if (state_q == RUN) begin
      if (!(&cyc_q))                  cyc_d = cyc_q + CNT_W'(1);
      if (!Ack && taken && !(&jmp_q)) jmp_d = jmp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cyc_q <= '0;
      jmp_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      jmp_q <= jmp_d;
    end
  end

  assign CycleCt = cyc_q;
  assign JumpCt  = jmp_q;
`else
  assign CycleCt = '0;
  assign JumpCt  = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequencing, branches, PC wrap, Ack priority, mid-run reset.
module tb_fetch_unit;
  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic             Clk = 1'b0;
  logic             Reset, Start, JumpEqual, JumpNotEqual, Equal, Ack;
  logic [PC_W-1:0]  StartAddr, Target;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running, Done;
  logic [CNT_W-1:0] CycleCt, JumpCt;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .JumpEqual(JumpEqual), .JumpNotEqual(JumpNotEqual), .Equal(Equal),
    .Target(Target), .Ack(Ack), .ProgCtr(ProgCtr), .Running(Running),
    .Done(Done), .CycleCt(CycleCt), .JumpCt(JumpCt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change #1 after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_br();
    JumpEqual = 1'b0; JumpNotEqual = 1'b0; Equal = 1'b0; Ack = 1'b0; Target = '0;
  endtask

  task automatic check_state(input string tag, input logic [PC_W-1:0] pc,
                             input logic run, input logic done);
    check({tag, "_pc"},   32'(ProgCtr), 32'(pc));
    check({tag, "_run"},  32'(Running), 32'(run));
    check({tag, "_done"}, 32'(Done),    32'(done));
  endtask

  task automatic check_cnt(input string tag, input int cyc, input int jmp);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_cyc"}, 32'(CycleCt), 32'(cyc));
    check({tag, "_jmp"}, 32'(JumpCt),  32'(jmp));
`else
    check({tag, "_cyc"}, 32'(CycleCt), 32'd0);
    check({tag, "_jmp"}, 32'(JumpCt),  32'd0);
`endif
  endtask

  // One branch decision at the current PC, then check the resulting PC.
  task automatic branch(input string tag, input logic je, input logic jne, input logic eq,
                        input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] exp_pc);
    JumpEqual = je; JumpNotEqual = jne; Equal = eq; Target = tgt;
    step();
    clear_br();
    check_state(tag, exp_pc, 1'b1, 1'b0);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; StartAddr = '0;
    clear_br();

    // 1: reset then idle hold
    step(); step();
    check_state("rst", 10'd0, 1'b0, 1'b0);
    check_cnt("rst", 0, 0);
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_state("idle", 10'd0, 1'b0, 1'b0);
    end

    // 2: straight-line run 4..7, Ack at 7
    StartAddr = 10'd4; Start = 1'b1;
    step();
    Start = 1'b0;
    check_state("go4", 10'd4, 1'b1, 1'b0);
    check_cnt("go4", 0, 0);
    for (int p = 5; p <= 7; p++) begin
      step();
      check_state("seq", PC_W'(p), 1'b1, 1'b0);
    end
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    check_state("halt7", 10'd7, 1'b0, 1'b1);
    check_cnt("halt7", 4, 0);
    step();
    check_state("hold7", 10'd7, 1'b0, 1'b1);
    check_cnt("hold7", 4, 0);

    // 3: branches from PC=5
    StartAddr = 10'd5; Start = 1'b1;
    step();
    Start = 1'b0;
    check_state("go5", 10'd5, 1'b1, 1'b0);
    check_cnt("go5", 0, 0);
    branch("je_t",  1'b1, 1'b0, 1'b1, 10'd20,  10'd20);
    branch("jne_t", 1'b0, 1'b1, 1'b0, 10'd5,   10'd5);
    branch("je_nt", 1'b1, 1'b0, 1'b0, 10'd20,  10'd6);
    branch("jne_3", 1'b0, 1'b1, 1'b0, 10'd3,   10'd3);
    branch("both",  1'b1, 1'b1, 1'b1, 10'd100, 10'd100);
    branch("jne_n", 1'b0, 1'b1, 1'b1, 10'd200, 10'd101);
    check_cnt("br", 6, 4);
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    check_state("halt101", 10'd101, 1'b0, 1'b1);
    check_cnt("halt101", 7, 4);

    // 4: wrap at top of address space; Start with a new address is ignored in RUN
    StartAddr = 10'h3FE; Start = 1'b1;
    step();
    check_state("go3fe", 10'h3FE, 1'b1, 1'b0);
    check_cnt("go3fe", 0, 0);
    StartAddr = 10'd0;
    step();
    check_state("w3ff", 10'h3FF, 1'b1, 1'b0);
    step();
    check_state("w000", 10'h000, 1'b1, 1'b0);
    step();
    Start = 1'b0;
    check_state("w001", 10'h001, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step();
    check_state("at9", 10'd9, 1'b1, 1'b0);

    // 5: Ack beats a taken jump
    Ack = 1'b1; JumpEqual = 1'b1; Equal = 1'b1; Target = 10'd50;
    step();
    clear_br();
    check_state("ackpri", 10'd9, 1'b0, 1'b1);
    check_cnt("ackpri", 12, 0);
    StartAddr = 10'd0; Start = 1'b1;
    step();
    Start = 1'b0;
    check_state("go0", 10'd0, 1'b1, 1'b0);
    check_cnt("go0", 0, 0);

    // 6: reset mid-run at PC=12 dominates Start
    for (int i = 0; i < 12; i++) step();
    check_state("at12", 10'd12, 1'b1, 1'b0);
    check_cnt("at12", 12, 0);
    Reset = 1'b0; Start = 1'b1; StartAddr = 10'd33;
    step();
    check_state("mrst", 10'd0, 1'b0, 1'b0);
    check_cnt("mrst", 0, 0);
    Reset = 1'b1; Start = 1'b0;
    step();
    check_state("post", 10'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
